// File: rtl/logicnet_in_pkg.sv
// Shared types, default thresholds and the quantizer for the layer-0 input stage.
// Pure declarations and a combinational helper; no latency of its own.
// No flow control here; used by the threshold bank and the packer.
package logicnet_in_pkg;

  localparam int Q_IN_BITS  = 16;
  localparam int Q_OUT_BITS = 2;
  localparam int NT         = (1 << Q_OUT_BITS) - 1;

  typedef logic [Q_IN_BITS-1:0]          th_word_t;
  typedef logic [NT-1:0][Q_IN_BITS-1:0]  th_set_t;

  // Index 0 holds the lowest default threshold.
  localparam th_set_t TH_DEFAULT = {16'hC000, 16'h8000, 16'h4000};

  // Number of thresholds the value meets or exceeds; thresholds need not be ordered.
  function automatic logic [Q_OUT_BITS-1:0] quant_code(input th_word_t value, input th_set_t th);
    logic [Q_OUT_BITS:0] cnt;
    cnt = '0;
    for (int k = 0; k < NT; k++) begin
      if (value >= th[k]) cnt = cnt + 1'b1;
    end
    if (cnt > (Q_OUT_BITS+1)'(NT)) cnt = (Q_OUT_BITS+1)'(NT);
    return cnt[Q_OUT_BITS-1:0];
  endfunction

endpackage

// File: rtl/threshold_bank.sv
// Per-feature threshold register file with one write port and one feature-wide read port.
// Writes land on the next clock edge; reads are combinational from the registers.
// No backpressure: out-of-range feature or threshold numbers are silently dropped.
module threshold_bank
  import logicnet_in_pkg::*;
#(
  parameter int NUM_FEATURES = 49,
  parameter int IDX_W        = $clog2(NUM_FEATURES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_feat,
  input  logic [Q_OUT_BITS-1:0] cfg_sel,
  input  th_word_t              cfg_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output th_set_t               rd_th
);

  th_set_t th [NUM_FEATURES];
  logic    wr_ok;

  // Selector value NT addresses no threshold, so it is treated as a no-op.
  assign wr_ok = cfg_we && (32'(cfg_feat) < NUM_FEATURES) && (32'(cfg_sel) < NT);

  // Reset restores every feature to the defaults; otherwise apply a valid write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FEATURES; f++) th[f] <= TH_DEFAULT;
    end else if (wr_ok) begin
      th[cfg_feat][cfg_sel] <= cfg_data;
    end
  end

  // A write in the same cycle as a read of that feature is seen one cycle later.
  assign rd_th = th[rd_idx];

endmodule

// File: rtl/input_quant_packer.sv
// Quantizes one raw feature per beat and packs a full frame into the layer-0 input vector.
// Latency: packed frame valid one cycle after the last beat is accepted.
// Backpressure: only the final beat of a frame stalls, and only while the output slot is full and not draining.
module input_quant_packer
  import logicnet_in_pkg::*;
#(
  parameter int NUM_FEATURES = 49,
  parameter int IN_BITS      = Q_IN_BITS,
  parameter int OUT_BITS     = Q_OUT_BITS,
  parameter int IDX_W        = $clog2(NUM_FEATURES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [IN_BITS-1:0]               s_data,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [NUM_FEATURES*OUT_BITS-1:0] m_data,
  input  logic                             cfg_we,
  input  logic [IDX_W-1:0]                 cfg_feat,
  input  logic [OUT_BITS-1:0]              cfg_sel,
  input  logic [IN_BITS-1:0]               cfg_data,
  output logic                             err_frame,
  input  logic                             err_clr
);

  localparam int               VEC_W    = NUM_FEATURES * OUT_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  logic [IDX_W-1:0]    idx;
  logic [VEC_W-1:0]    acc;
  logic [VEC_W-1:0]    acc_merged;
  th_set_t             th_cur;
  logic [OUT_BITS-1:0] code;
  logic                at_last;
  logic                accept;
  logic                frame_done;
  logic                frame_err;

  threshold_bank #(
    .NUM_FEATURES (NUM_FEATURES),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_feat (cfg_feat),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .rd_idx   (idx),
    .rd_th    (th_cur)
  );

  // Ready depends only on state and m_ready, never on s_valid.
  assign at_last    = (idx == LAST_IDX);
  assign s_ready    = !at_last || !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign code       = quant_code(s_data, th_cur);
  assign frame_done = accept && at_last;
  // s_last must coincide exactly with the final feature; either mismatch is an error.
  assign frame_err  = accept && (at_last ? !s_last : s_last);

  // Accumulator with the current beat's code dropped into its slot.
  always_comb begin
    acc_merged = acc;
    acc_merged[idx*OUT_BITS +: OUT_BITS] = code;
  end

  // Feature index and partial-frame accumulator; early s_last discards the partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      if (at_last || s_last) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + 1'b1;
        acc <= acc_merged;
      end
    end
  end

  // Output slot: a completing frame overwrites even while the old one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (frame_done) begin
      m_valid <= 1'b1;
      m_data  <= acc_merged;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky framing error; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_frame <= 1'b0;
    end else if (frame_err) begin
      err_frame <= 1'b1;
    end else if (err_clr) begin
      err_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_quant_packer.sv
// Bench for the input quantizer/packer with a 4-feature frame.
// Reference is a frame-level model: threshold table, list of codes, expected output slot.
// Directed scenarios first, then a randomized run with per-cycle checks.
module tb_input_quant_packer;

  localparam int NF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_feat = '0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_data = '0;
  logic        err_frame;
  logic        err_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] th_m [NF][3];
  int          m_idx;
  int          codes [NF];
  bit          exp_mvalid;
  logic [7:0]  exp_mdata;
  bit          exp_err;
  bit          rdy_seen;
  bit          rdy_exp;

  always #5 clk = ~clk;

  input_quant_packer #(.NUM_FEATURES(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_we    (cfg_we),
    .cfg_feat  (cfg_feat),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .err_frame (err_frame),
    .err_clr   (err_clr)
  );

  function automatic void model_reset();
    for (int f = 0; f < NF; f++) begin
      th_m[f][0] = 16'h4000;
      th_m[f][1] = 16'h8000;
      th_m[f][2] = 16'hC000;
      codes[f] = 0;
    end
    m_idx = 0;
    exp_mvalid = 1'b0;
    exp_mdata = '0;
    exp_err = 1'b0;
  endfunction

  function automatic int ref_code(int f, logic [15:0] v);
    int n = 0;
    for (int k = 0; k < 3; k++) if (v >= th_m[f][k]) n++;
    return n;
  endfunction

  // One clock: sample ready, advance the model at the edge, settle 1 time unit after.
  task automatic tick();
    int         cd;
    bit         acc;
    logic [7:0] pk;
    #1;
    rdy_seen = s_ready;
    rdy_exp  = (m_idx != NF-1) || !exp_mvalid || m_ready;
    acc      = s_valid && rdy_exp;
    cd       = ref_code(m_idx, s_data);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (acc && m_idx == NF-1) begin
        codes[NF-1] = cd;
        pk = '0;
        for (int i = 0; i < NF; i++) pk = pk | (8'(codes[i]) << (2*i));
        exp_mdata  = pk;
        exp_mvalid = 1'b1;
      end else if (m_ready) begin
        exp_mvalid = 1'b0;
      end
      if (acc && ((m_idx == NF-1) != s_last)) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
      if (acc) begin
        if (m_idx == NF-1 || s_last) m_idx = 0;
        else begin
          codes[m_idx] = cd;
          m_idx++;
        end
      end
      if (cfg_we && cfg_sel < 2'd3) th_m[cfg_feat][cfg_sel] = cfg_data;
    end
    #1;
  endtask

  task automatic beat(input logic [15:0] v, input bit last);
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_frame); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    beat(16'h0000, 1'b0);
    beat(16'h4000, 1'b0);
    beat(16'h9000, 1'b0);
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %b want 0", m_valid); end
    beat(16'hFFFF, 1'b1);
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", m_valid); end
    vectors++; if (m_data !== 8'b11_10_01_00) begin miscompares++; $display("FAIL basic_data: got %b want 11100100", m_data); end
    vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b want 0", err_frame); end
    tick();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] f1;
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) beat(16'($urandom), i == NF-1);
    f1 = exp_mdata;
    vectors++; if (m_valid !== 1'b1 || m_data !== f1) begin miscompares++; $display("FAIL bp_frame1: got v=%b d=%h want v=1 d=%h", m_valid, m_data, f1); end
    for (int i = 0; i < NF-1; i++) begin
      beat(16'($urandom), 1'b0);
      vectors++; if (rdy_seen !== 1'b1) begin miscompares++; $display("FAIL bp_ready_beat%0d: got %b want 1", i, rdy_seen); end
      vectors++; if (m_data !== f1 || m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, f1); end
    end
    s_valid = 1'b1; s_data = 16'($urandom); s_last = 1'b1;
    tick();
    vectors++; if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready: got %b want 0", rdy_seen); end
    vectors++; if (m_data !== f1) begin miscompares++; $display("FAIL bp_stall_hold: got %h want %h", m_data, f1); end
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (rdy_seen !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", rdy_seen); end
    vectors++; if (m_valid !== 1'b1 || m_data !== exp_mdata) begin miscompares++; $display("FAIL bp_frame2: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp_mdata); end
    tick();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", m_valid); end
  endtask

  task automatic test_early_last();
    m_ready = 1'b1;
    beat(16'($urandom), 1'b0);
    beat(16'($urandom), 1'b1);
    tick();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL early_no_emit: got %b want 0", m_valid); end
    vectors++; if (err_frame !== 1'b1) begin miscompares++; $display("FAIL early_err: got %b want 1", err_frame); end
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) beat(16'($urandom), i == NF-1);
    vectors++; if (m_valid !== 1'b1 || m_data !== exp_mdata) begin miscompares++; $display("FAIL early_next_frame: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp_mdata); end
    m_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (err_frame !== 1'b0) begin miscompares++; $display("FAIL early_clear: got %b want 0", err_frame); end
    err_clr = 1'b1;
    beat(16'($urandom), 1'b1);
    err_clr = 1'b0;
    vectors++; if (err_frame !== 1'b1) begin miscompares++; $display("FAIL early_set_wins: got %b want 1", err_frame); end
  endtask

  task automatic test_missing_last();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) beat(16'($urandom), 1'b0);
    vectors++; if (m_valid !== 1'b1 || m_data !== exp_mdata) begin miscompares++; $display("FAIL missing_emit: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp_mdata); end
    vectors++; if (err_frame !== 1'b1) begin miscompares++; $display("FAIL missing_err: got %b want 1", err_frame); end
    m_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_config();
    m_ready = 1'b0;
    beat(16'($urandom), 1'b0);
    beat(16'($urandom), 1'b0);
    cfg_we = 1'b1; cfg_feat = 2'd2; cfg_sel = 2'd0; cfg_data = 16'h0100;
    tick();
    cfg_we = 1'b0;
    beat(16'h0200, 1'b0);
    m_ready = 1'b1;
    beat(16'($urandom), 1'b1);
    vectors++; if (m_data[5:4] !== 2'd1) begin miscompares++; $display("FAIL cfg_new_th: got %0d want 1", m_data[5:4]); end
    vectors++; if (m_data !== exp_mdata) begin miscompares++; $display("FAIL cfg_frame_a: got %h want %h", m_data, exp_mdata); end
    beat(16'($urandom), 1'b0);
    cfg_we = 1'b1; cfg_feat = 2'd1; cfg_sel = 2'd0; cfg_data = 16'h0001;
    beat(16'h0002, 1'b0);
    cfg_we = 1'b0;
    beat(16'($urandom), 1'b0);
    beat(16'($urandom), 1'b1);
    vectors++; if (m_data[3:2] !== 2'd0) begin miscompares++; $display("FAIL cfg_old_th: got %0d want 0", m_data[3:2]); end
    vectors++; if (m_data !== exp_mdata) begin miscompares++; $display("FAIL cfg_frame_b: got %h want %h", m_data, exp_mdata); end
    cfg_we = 1'b1; cfg_feat = 2'd0; cfg_sel = 2'd3; cfg_data = 16'h0000;
    tick();
    cfg_we = 1'b0;
    beat(16'h5000, 1'b0);
    beat(16'h0002, 1'b0);
    beat(16'($urandom), 1'b0);
    beat(16'($urandom), 1'b1);
    vectors++; if (m_data[3:0] !== 4'b01_01) begin miscompares++; $display("FAIL cfg_sel_nt_ignored: got %b want 0101", m_data[3:0]); end
    tick();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) beat(16'($urandom), i == NF-1);
    beat(16'($urandom), 1'b0);
    beat(16'($urandom), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
    vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h want 00", m_data); end
    m_ready = 1'b1;
    beat(16'h1000, 1'b0);
    beat(16'h8000, 1'b0);
    beat(16'h0200, 1'b0);
    beat(16'hC000, 1'b1);
    vectors++; if (m_valid !== 1'b1 || m_data !== 8'b11_00_10_00) begin miscompares++; $display("FAIL rstmid_frame: got v=%b d=%b want v=1 d=11001000", m_valid, m_data); end
    tick();
  endtask

  task automatic test_random();
    int sel;
    for (int c = 0; c < 600; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) s_data = 16'(int'(th_m[m_idx][sel]) + $urandom_range(0, 2) - 1);
      else s_data = 16'($urandom);
      s_last  = (m_idx == NF-1) ^ ($urandom_range(0, 15) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_feat = 2'($urandom);
      cfg_sel  = 2'($urandom);
      cfg_data = 16'($urandom);
      err_clr  = ($urandom_range(0, 7) == 0);
      tick();
      vectors++; if (rdy_seen !== rdy_exp) begin miscompares++; $display("FAIL rand_ready c%0d: got %b want %b", c, rdy_seen, rdy_exp); end
      vectors++; if (m_valid !== exp_mvalid) begin miscompares++; $display("FAIL rand_valid c%0d: got %b want %b", c, m_valid, exp_mvalid); end
      vectors++; if (err_frame !== exp_err) begin miscompares++; $display("FAIL rand_err c%0d: got %b want %b", c, err_frame, exp_err); end
      if (exp_mvalid) begin
        vectors++; if (m_data !== exp_mdata) begin miscompares++; $display("FAIL rand_data c%0d: got %h want %h", c, m_data, exp_mdata); end
      end
    end
    s_valid = 1'b0; s_last = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_config();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_quant_packer.md
Name: input_quant_packer

Overview:
- Upstream stage of the layer-0 LogicNets neuron array.
- Accepts raw IIoT feature samples one per beat over a valid/ready stream and quantizes each to OUT_BITS by comparing against per-feature runtime-loadable thresholds.
- Packs one full frame of quantized features into the flat input vector that feeds the layer-0 neuron LUTs.
- Presents the packed vector to layer 0 with a valid/ready handshake, double-buffered so input streaming continues while the previous frame drains.

Parameters:
- NUM_FEATURES, 49, features per frame (one beat each).
- IN_BITS, 16, raw feature width, unsigned.
- OUT_BITS, 2, quantized width per feature; thresholds per feature NT = 2^OUT_BITS - 1.
- IDX_W, $clog2(NUM_FEATURES), width of the feature index and config feature address.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  raw feature beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  IN_BITS  raw feature value, unsigned.
- s_last  in  1  marks the final feature of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  layer 0 accepts the frame.
- m_data  out  NUM_FEATURES*OUT_BITS  packed frame; feature i occupies [i*OUT_BITS +: OUT_BITS].
- cfg_we  in  1  threshold write strobe.
- cfg_feat  in  IDX_W  feature index of the threshold being written.
- cfg_sel  in  OUT_BITS  threshold number, 0..NT-1. A write with cfg_sel = NT is ignored.
- cfg_data  in  IN_BITS  threshold value.
- err_frame  out  1  sticky framing error flag.
- err_clr  in  1  clears err_frame.

Behaviour:
- **Reset (synchronous):**
  - idx = 0, accumulator = 0, m_valid = 0, m_data = 0, err_frame = 0.
  - Thresholds load the package defaults TH_DEFAULT[k] for every feature.
- **Beat acceptance:** a beat is accepted when s_valid && s_ready.
- **Quantization:**
  - code = count of k in 0..NT-1 with s_data >= th[idx][k], using an unsigned compare, saturating at NT.
  - Thresholds are not required to be monotonic; the count is taken as-is.
- **Packing:**
  - On acceptance, code is written into accumulator[idx*OUT_BITS +: OUT_BITS] and idx increments.
- **Frame completion:** occurs when a beat is accepted at idx = NUM_FEATURES-1. On that edge:
  - the accumulator, with the final code merged in, copies into the m_data register;
  - m_valid = 1;
  - idx returns to 0;
  - the accumulator clears.
- **Latency:** m_valid rises on the cycle after the last beat is accepted.
- **s_ready:**
  - s_ready = 1 when idx != NUM_FEATURES-1.
  - At idx = NUM_FEATURES-1, s_ready = (!m_valid || m_ready), so the output slot is free or draining in the same cycle.
  - No combinational path from s_valid to s_ready.
- **Output handshake:**
  - m_valid and m_data hold stable until m_ready.
  - A simultaneous drain and new frame completion leaves m_valid = 1 with the new data.
  - A drain without a new frame sets m_valid = 0.
- **Framing errors:**
  - Early s_last (idx < NUM_FEATURES-1): the partial frame is dropped, idx = 0, accumulator clears, err_frame = 1, and nothing is emitted.
  - Missing s_last at idx = NUM_FEATURES-1: the frame is emitted normally and err_frame = 1.
  - err_clr clears err_frame. If err_clr and a new error occur in the same cycle, set wins.
- **Config writes:**
  - Take effect on the next cycle at any time.
  - If a write and a beat accept coincide on the same feature, the beat uses the old threshold.
  - cfg_feat >= NUM_FEATURES is ignored.
- **Reset mid-frame:** the partial frame and any pending m_data are discarded, and thresholds revert to defaults.

Decomposition:
- **Package logicnet_in_pkg:**
  - TH_DEFAULT constant array.
  - Function quant_code(value, thresholds) returning the saturating count.
  - Localparam NT derivation.
- **Sub-module threshold_bank:**
  - NUM_FEATURES × NT × IN_BITS register file.
  - Write port: cfg_*.
  - Read port: NT thresholds indexed by idx.
- **Top:** the remaining control (index counter, accumulator, output slot, error logic) stays in the top module.

Test Plan:
- NUM_FEATURES=4, defaults {0x4000,0x8000,0xC000}:
  - Stimulus: beats 0x0000, 0x4000, 0x9000, 0xFFFF with s_last on the 4th, m_ready=1.
  - Required: codes 0,1,2,3; m_data=8'b11_10_01_00; m_valid exactly 1 cycle after the 4th accept.
- Backpressure:
  - Stimulus: m_ready=0 after the first frame, then stream a second frame.
  - Required: s_ready drops only at idx=3; m_data holds frame 1. Raising m_ready drains frame 1 and accepts beat 3 in the same cycle; frame 2 follows with no bubble.
- Early s_last:
  - Stimulus: s_last on the 2nd beat.
  - Required: no m_valid; err_frame=1; the next 4 beats form a correct frame. err_clr then gives err_frame=0.
- Missing s_last:
  - Stimulus: 4 beats with no s_last.
  - Required: the frame is emitted and err_frame=1.
- Config write:
  - Stimulus: write th[2][0]=0x0100. A beat for feature 2 with value 0x0200, accepted the cycle after the write, is checked first. Then a write th[1][0]=0x0001 is issued in the same cycle as a feature-1 beat of 0x0002.
  - Required: the feature-2 code is 1, using the new threshold. The feature-1 code is 0, using the old threshold.
- Reset mid-frame:
  - Stimulus: rst after 2 beats, with a modified threshold and pending m_valid.
  - Required: m_valid=0, idx=0, defaults restored; the next frame is packed from feature 0.
